// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit for the multicycle datapath. Computes
//   MULT / MULTU / DIV / DIVU one bit per clock into HI/LO. The unit works on
//   operand magnitudes and corrects the signs of the results on the last step.
//   A start/busy/done handshake lets the control FSM stall while an operation
//   is in flight.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      operation request, sampled only in IDLE
//   op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_in         in   WIDTH  multiplicand / dividend
//   b_in         in   WIDTH  multiplier / divisor
//   busy         out  1      high while in RUN or DONE
//   done         out  1      one-cycle completion pulse
//   div_by_zero  out  1      last DIV/DIVU had a zero divisor
//   hi           out  WIDTH  product upper half or remainder
//   lo           out  WIDTH  product lower half or quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; the most negative value maps onto its
  // unsigned magnitude, which the unsigned iteration handles correctly.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    is_signed);
    if (is_signed && v[WIDTH-1])
      magnitude = WIDTH'(-v);
    else
      magnitude = v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             negate);
    apply_sign = negate ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic               negate);
    apply_sign_wide = negate ? (2*WIDTH)'(-v) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // quotient / product must be negated
  logic             rneg_q, rneg_d;     // remainder must be negated
  logic [WIDTH-1:0] opb_q, opb_d;       // multiplicand magnitude or divisor magnitude
  logic [AW-1:0]    acc_q, acc_d;       // shared shift register for both operations
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Step datapath
  logic [WIDTH:0]     mul_sum;
  logic [AW-1:0]      mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [AW-1:0]      div_next;
  logic [AW-1:0]      step_next;

  // Issue-side operand decode
  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  always_comb begin
    // Multiply: acc = {upper partial product (WIDTH+1), multiplier bits}.
    // The upper field enters each step with its top bit clear, so the add
    // of a WIDTH-bit multiplicand cannot overflow WIDTH+1 bits.
    mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {0, remainder, dividend/quotient bits}.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo   = {acc_q[WIDTH-2:0], div_ge};
    div_next  = {1'b0, div_rem, div_quo};

    step_next = is_div_q ? div_next : mul_next;
  end

  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    a_mag     = magnitude(a_in, op_signed);
    b_mag     = magnitude(b_in, op_signed);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op_div;
          neg_d    = op_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          rneg_d   = op_signed & op_div & a_in[WIDTH-1];
          cnt_d    = '0;
          if (op_div && (b_in == '0)) begin
            // Zero divisor completes immediately with a fixed result.
            hi_d    = a_in;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dbz_d   = 1'b0;
            opb_d   = op_div ? b_mag : a_mag;
            acc_d   = {{(WIDTH+1){1'b0}}, (op_div ? a_mag : b_mag)};
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (is_div_q) begin
            hi_d = apply_sign(div_rem, rneg_q);
            lo_d = apply_sign(div_quo, neg_q);
          end else begin
            {hi_d, lo_d} = apply_sign_wide(mul_next[2*WIDTH-1:0], neg_q);
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
